// File: rtl/axi_burst_pixel_reader.sv
// AXI4-style burst read master wired to a word-addressed pattern memory slave,
// with each returned RGB beat accompanied by its combinational channel mean.
module axi_burst_pixel_reader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]           read_len,
  input  logic [2:0]            read_size,
  input  logic [1:0]            read_burst,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rlast,
  output logic [7:0]            rgb_mean_out
);

  localparam int unsigned IDX_W = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {M_IDLE, M_ADDR, M_DATA} m_state_t;
  typedef enum logic       {S_IDLE, S_BURST}        s_state_t;

  m_state_t m_state, m_next;
  s_state_t s_state, s_next;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [1:0]            arburst;
  logic                  arvalid, arready, rready;
  logic                  accept, ar_fire, r_fire;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [IDX_W-1:0]      idx;
  logic [8:0]            remaining;
  logic                  fixed_burst;
  logic [9:0]            rgb_sum;

  // Beats are always 4 bytes, so size and sub-word/upper address bits are ignored.
  logic unused;
  assign unused = ^{read_size, araddr[ADDR_WIDTH-1:IDX_W+2], araddr[1:0]};

  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;

  // Master
  always_ff @(posedge clk) begin
    if (!rst_n) m_state <= M_IDLE;
    else        m_state <= m_next;
  end

  always_comb begin
    m_next  = m_state;
    arvalid = 1'b0;
    rready  = 1'b0;
    accept  = 1'b0;
    case (m_state)
      M_IDLE: begin
        if (start_read && (read_len != 32'd0)) begin
          accept = 1'b1;
          m_next = M_ADDR;
        end
      end
      M_ADDR: begin
        arvalid = 1'b1;
        if (ar_fire) m_next = M_DATA;
      end
      M_DATA: begin
        rready = 1'b1;
        if (r_fire && rlast) m_next = M_IDLE;
      end
      default: m_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      araddr  <= '0;
      arlen   <= '0;
      arburst <= '0;
      done    <= 1'b0;
    end else begin
      done <= (m_state == M_DATA) && r_fire && rlast;
      if (accept) begin
        araddr  <= read_addr;
        arlen   <= 8'(read_len - 32'd1);
        arburst <= read_burst;
      end
    end
  end

  assign busy = (m_state != M_IDLE);

  // Slave
  always_ff @(posedge clk) begin
    if (!rst_n) s_state <= S_IDLE;
    else        s_state <= s_next;
  end

  always_comb begin
    s_next  = s_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    case (s_state)
      S_IDLE: begin
        arready = 1'b1;
        if (arvalid) s_next = S_BURST;
      end
      S_BURST: begin
        rvalid = 1'b1;
        rlast  = (remaining == 9'd1);
        if (rready && rlast) s_next = S_IDLE;
      end
      default: s_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= '0;
      remaining   <= '0;
      fixed_burst <= 1'b0;
    end else if (s_state == S_IDLE) begin
      if (arvalid) begin
        idx         <= araddr[IDX_W+1:2];
        remaining   <= {1'b0, arlen} + 9'd1;
        fixed_burst <= (arburst == 2'b00);
      end
    end else if (r_fire) begin
      remaining <= remaining - 9'd1;
      // Index width equals log2(MEM_SIZE), so INCR wraps to 0 naturally.
      if (!fixed_burst) idx <= idx + 1'b1;
    end
  end

  // Pattern memory, reloaded whenever reset is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_SIZE; i++)
        mem[i] <= {8'h00, 8'(i), 8'(i + 1), 8'(i + 2)};
    end
  end

  assign rdata = rvalid ? mem[idx] : '0;

  assign rgb_sum      = {2'b00, rdata[23:16]} + {2'b00, rdata[15:8]} + {2'b00, rdata[7:0]};
  assign rgb_mean_out = 8'(rgb_sum / 10'd3);

endmodule

// File: tb/tb_axi_burst_pixel_reader.sv
// Bench for axi_burst_pixel_reader: directed and random bursts checked cycle by
// cycle against an address-arithmetic model of the pattern memory.
module tb_axi_burst_pixel_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_read;
  logic [31:0] read_addr;
  logic [31:0] read_len;
  logic [2:0]  read_size;
  logic [1:0]  read_burst;
  logic        busy, done, rvalid, rlast;
  logic [31:0] rdata;
  logic [7:0]  rgb_mean_out;

  int checks = 0;
  int errors = 0;

  axi_burst_pixel_reader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(256)) dut (
    .clk(clk), .rst_n(rst_n), .start_read(start_read), .read_addr(read_addr),
    .read_len(read_len), .read_size(read_size), .read_burst(read_burst),
    .busy(busy), .done(done), .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
    .rgb_mean_out(rgb_mean_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pix(input int unsigned i);
    int unsigned w = i % 256;
    return {8'h00, 8'(w), 8'((w + 1) % 256), 8'((w + 2) % 256)};
  endfunction

  function automatic logic [7:0] mean_of(input int unsigned i);
    int unsigned w = i % 256;
    return 8'((w + (w + 1) % 256 + (w + 2) % 256) / 3);
  endfunction

  task automatic check_idle_outputs(input string name, input logic exp_done);
    checks++;
    if (busy !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || done !== exp_done ||
        rdata !== 32'h0 || rgb_mean_out !== 8'h0) begin
      errors++;
      $display("FAIL %s: busy=%b rvalid=%b rlast=%b done=%b rdata=%h mean=%0d required busy=0 rvalid=0 rlast=0 done=%b rdata=0 mean=0",
               name, busy, rvalid, rlast, done, rdata, rgb_mean_out, exp_done);
    end
  endtask

  // Issues one command and checks every cycle until one past the done pulse.
  // poke: re-strobe start_read (len 5) while the burst is in flight.
  task automatic run_burst(input string name, input logic [31:0] addr, input int unsigned len,
                           input logic [1:0] burst, input bit poke);
    int unsigned n = ((len - 1) % 256) + 1;
    int unsigned base = addr / 4;
    @(negedge clk);
    read_addr = addr; read_len = len; read_burst = burst; read_size = 3'b010;
    start_read = 1'b1;
    @(posedge clk); #1;
    start_read = 1'b0;
    checks++;
    if (busy !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s E0: busy=%b rvalid=%b required busy=1 rvalid=0", name, busy, rvalid);
    end
    for (int unsigned c = 1; c <= n + 1; c++) begin
      @(posedge clk); #1;
      if (c <= n) begin
        int unsigned w = (burst == 2'b00) ? base : base + c - 1;
        logic [31:0] ed = pix(w);
        logic [7:0]  em = mean_of(w);
        checks++;
        if (rvalid !== 1'b1 || rdata !== ed || rgb_mean_out !== em ||
            rlast !== (c == n) || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s beat %0d: rvalid=%b rdata=%h mean=%0d rlast=%b busy=%b done=%b required rvalid=1 rdata=%h mean=%0d rlast=%b busy=1 done=0",
                   name, c - 1, rvalid, rdata, rgb_mean_out, rlast, busy, done, ed, em, (c == n));
        end
      end else begin
        check_idle_outputs({name, " end"}, 1'b1);
      end
      if (poke && c == 1) begin
        read_len = 5; start_read = 1'b1;
      end
      if (poke && c == 2) start_read = 1'b0;
    end
    for (int unsigned c = 0; c < (poke ? 8 : 1); c++) begin
      @(posedge clk); #1;
      check_idle_outputs({name, " after"}, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_read = 1'b0; read_addr = '0; read_len = '0;
    read_size = 3'b010; read_burst = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset", 1'b0);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_incr();
    run_burst("incr0_len8", 32'h0, 8, 2'b01, 1'b0);
  endtask

  task automatic test_wrap();
    run_burst("wrap254", 32'h3F8, 4, 2'b01, 1'b0);
  endtask

  task automatic test_fixed();
    run_burst("fixed40", 32'h40, 3, 2'b00, 1'b0);
  endtask

  task automatic test_busy_ignore();
    run_burst("busy_poke", 32'h100, 4, 2'b11, 1'b1);
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    read_addr = 32'h20; read_len = 0; read_burst = 2'b01; start_read = 1'b1;
    @(negedge clk); start_read = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check_idle_outputs("len0", 1'b0);
    end
  endtask

  task automatic test_len_truncate();
    run_burst("len258", 32'h80, 258, 2'b01, 1'b0);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    read_addr = 32'h0; read_len = 8; read_burst = 2'b01; start_read = 1'b1;
    @(posedge clk); #1; start_read = 1'b0;
    for (int unsigned c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rvalid !== 1'b1 || rdata !== pix(c - 1)) begin
        errors++;
        $display("FAIL midrst beat %0d: rvalid=%b rdata=%h required rvalid=1 rdata=%h",
                 c - 1, rvalid, rdata, pix(c - 1));
      end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle_outputs("midrst", 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
      check_idle_outputs("midrst quiet", 1'b0);
    end
    run_burst("post_rst", 32'h10, 2, 2'b01, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      logic [31:0] a = $urandom;
      int unsigned l = $urandom_range(20, 1);
      logic [1:0]  b = 2'($urandom_range(3, 0));
      run_burst($sformatf("rand%0d", t), a, l, b, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_busy_ignore();
    test_len_zero();
    test_len_truncate();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
